ldm_stream_dma: RTL and testbench

//  Single-clock DMA stage directly upstream of the dual-port local data memory (LDM).

---
 rtl/ldm_stream_dma_pkg.sv | 9 +
 rtl/ldm_stream_dma_if.sv | 25 ++
 rtl/ldm_stream_dma_skid.sv | 32 +++
 rtl/ldm_stream_dma.sv | 88 ++++++++
 tb/tb_ldm_stream_dma.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ldm_stream_dma_pkg.sv
// ldm_stream_dma_pkg: FSM state and mode encodings shared by the LDM stream DMA.
package ldm_stream_dma_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ  = 1'b1;
endpackage

// File: rtl/ldm_stream_dma_if.sv
// ldm_stream_dma_if: write stream, read stream and LDM port bundle; master is the DMA side.
interface ldm_stream_dma_if #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
);
    logic              s_valid;
    logic              s_ready;
    logic [DWIDTH-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DWIDTH-1:0] m_data;
    logic              ldm_en;
    logic              ldm_we;
    logic [AWIDTH-1:0] ldm_addr;
    logic [DWIDTH-1:0] ldm_din;
    logic [DWIDTH-1:0] ldm_dout;
    modport master (
        input  s_valid, s_data, m_ready, ldm_dout,
        output s_ready, m_valid, m_data, ldm_en, ldm_we, ldm_addr, ldm_din
    );
    modport slave (
        output s_valid, s_data, m_ready, ldm_dout,
        input  s_ready, m_valid, m_data, ldm_en, ldm_we, ldm_addr, ldm_din
    );
endinterface

// File: rtl/ldm_stream_dma_skid.sv
// ldm_skid_buf: 2-entry FIFO absorbing LDM read latency under downstream backpressure.
module ldm_skid_buf #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout,
    output logic [1:0]        count
);
    logic [DWIDTH-1:0] mem [2];
    logic wp, rp;
    assign dout = mem[rp];
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/ldm_stream_dma.sv
// ldm_stream_dma: stream<->LDM DMA stage; defining LDM_DMA_STRIDE_EN adds the cfg_stride address step.
module ldm_stream_dma
    import ldm_stream_dma_pkg::*;
#(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   length,
`ifdef LDM_DMA_STRIDE_EN
    input  logic [AWIDTH-1:0] cfg_stride,
`endif
    output logic              busy,
    output logic              done,
    ldm_stream_dma_if.master  bus
);
    localparam int IW = AWIDTH + 1;
    logic [1:0]        st, st_nxt;
    logic [IW-1:0]     len_q, issued;
    logic [AWIDTH-1:0] cur_addr, step;
    logic [1:0]        buf_cnt;
    logic [DWIDTH-1:0] buf_dout;
    logic              inflight, wr_beat, rd_issue, issue, pop;
`ifdef LDM_DMA_STRIDE_EN
    logic [AWIDTH-1:0] stride_q;
    always_ff @(posedge clk) begin
        if (rst) stride_q <= '0;
        else if (st == ST_IDLE && start) stride_q <= cfg_stride;
    end
    assign step = stride_q;
`else
    assign step = AWIDTH'(1);
`endif
    // A read may issue only if the skid buffer can still take it after its one-cycle flight.
    always_comb begin
        pop      = bus.m_valid & bus.m_ready;
        wr_beat  = st == ST_WRITE && bus.s_valid && bus.s_ready;
        rd_issue = st == ST_READ && issued != len_q && (buf_cnt + 2'(inflight) - 2'(pop)) < 2'd2;
        issue    = wr_beat | rd_issue;
        st_nxt   = st == ST_IDLE  ? (start ? (length == '0 ? ST_DONE : mode == MODE_READ ? ST_READ : ST_WRITE) : ST_IDLE)
                 : st == ST_WRITE ? (issued + IW'(wr_beat) == len_q ? ST_DONE : ST_WRITE)
                 : st == ST_READ  ? (issued == len_q && !inflight && buf_cnt == 2'(pop) ? ST_DONE : ST_READ)
                 : ST_IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= ST_IDLE;
            bus.s_ready <= 1'b0;
            len_q       <= '0;
            issued      <= '0;
            cur_addr    <= '0;
            inflight    <= 1'b0;
        end else begin
            st          <= st_nxt;
            bus.s_ready <= st_nxt == ST_WRITE;
            inflight    <= rd_issue;
            if (st == ST_IDLE && start) begin
                len_q    <= length;
                issued   <= '0;
                cur_addr <= base_addr;
            end else if (issue) begin
                issued   <= issued + IW'(1);
                cur_addr <= cur_addr + step;
            end
        end
    end
    ldm_skid_buf #(.DWIDTH(DWIDTH)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .din   (bus.ldm_dout),
        .dout  (buf_dout),
        .count (buf_cnt)
    );
    assign bus.ldm_en   = issue;
    assign bus.ldm_we   = wr_beat;
    assign bus.ldm_addr = issue ? cur_addr : '0;
    assign bus.ldm_din  = wr_beat ? bus.s_data : '0;
    assign bus.m_valid  = buf_cnt != 2'd0;
    assign bus.m_data   = buf_dout;
    assign busy         = st != ST_IDLE;
    assign done         = st == ST_DONE;
endmodule

// File: tb/tb_ldm_stream_dma.sv
// tb_ldm_stream_dma: scoreboard bench; stimulus queues expected LDM writes and read words, a monitor checks them.
module tb_ldm_stream_dma;
    localparam int AW = 10;
    localparam int DW = 32;
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
`ifdef LDM_DMA_STRIDE_EN
    logic [AW-1:0] cfg_stride = 10'd1;
`endif
    logic          busy, done;
    logic [DW-1:0] mem [1 << AW];
    int            total = 0, bad = 0, cyc = 0;
    int            done_cnt = 0, en_cnt = 0, rd_iss = 0;
    int            pop_cyc[$];
    wr_t           wq[$];
    logic [DW-1:0] rq[$];
    logic          stall_prev = 1'b0;
    logic [DW-1:0] held = '0;
    ldm_stream_dma_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();
    ldm_stream_dma #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .base_addr (base_addr),
        .length    (length),
`ifdef LDM_DMA_STRIDE_EN
        .cfg_stride(cfg_stride),
`endif
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // LDM behavioural model: synchronous write, one-cycle registered read.
    always @(posedge clk) begin
        if (bus.ldm_en && bus.ldm_we) mem[bus.ldm_addr] <= bus.ldm_din;
        if (bus.ldm_en && !bus.ldm_we) bus.ldm_dout <= mem[bus.ldm_addr];
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic launch(input logic m, input logic [AW-1:0] b, input logic [AW:0] l);
        start = 1'b1;
        mode = m;
        base_addr = b;
        length = l;
        step();
        start = 1'b0;
    endtask
    task automatic send(input logic [DW-1:0] d);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data = d;
        while (!bus.s_ready && n < 20) begin
            step();
            n++;
        end
        chk("s_ready_wait", 32'(bus.s_ready), 32'd1);
        step();
        bus.s_valid = 1'b0;
    endtask
    task automatic wait_done(input bit tog, output int at);
        int n = 0;
        while (!done && n < 200) begin
            if (tog) bus.m_ready = ~bus.m_ready;
            step();
            n++;
        end
        chk("done_wait", 32'(done), 32'd1);
        at = cyc;
    endtask
    initial begin
        int p0, d0, e0, at, n;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = 1'b0;
        fork
            begin
                wr_t w;
                forever begin
                    @(negedge clk);
                    if (done) done_cnt++;
                    if (bus.ldm_en) en_cnt++;
                    if (rst) begin
                        rd_iss = pop_cyc.size();
                        stall_prev = 1'b0;
                    end else begin
                        if (stall_prev) begin
                            chk("hold_valid", 32'(bus.m_valid), 32'd1);
                            chk("hold_data", bus.m_data, held);
                        end
                        if (bus.ldm_en && bus.ldm_we) begin
                            if (wq.size() == 0) begin
                                total++;
                                bad++;
                                $display("FAIL wr_unexpected: addr %h data %h with none queued", bus.ldm_addr, bus.ldm_din);
                            end else begin
                                w = wq.pop_front();
                                chk("wr_addr", 32'(bus.ldm_addr), 32'(w.a));
                                chk("wr_data", bus.ldm_din, w.d);
                            end
                        end
                        if (bus.m_valid && bus.m_ready) begin
                            if (rq.size() == 0) begin
                                total++;
                                bad++;
                                $display("FAIL rd_unexpected: data %h with none queued", bus.m_data);
                            end else chk("rd_data", bus.m_data, rq.pop_front());
                            pop_cyc.push_back(cyc);
                        end
                        if (bus.ldm_en && !bus.ldm_we) begin
                            rd_iss++;
                            chk("inflight_le2", 32'(rd_iss - pop_cyc.size() <= 2), 32'd1);
                        end
                        stall_prev = bus.m_valid && !bus.m_ready;
                        held = bus.m_data;
                    end
                end
            end
        join_none
        repeat (3) step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_s_ready", 32'(bus.s_ready), 0);
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_ldm_en", 32'(bus.ldm_en), 0);
        chk("rst_ldm_we", 32'(bus.ldm_we), 0);
        chk("rst_ldm_addr", 32'(bus.ldm_addr), 0);
        chk("rst_m_data", bus.m_data, 0);
        rst = 1'b0;
        step();
        // write wrapping past the top of the LDM, with an ignored start mid-transfer
        for (int i = 0; i < 4; i++) wq.push_back('{AW'(10'h3FE + i), 32'hA0 + i});
        launch(1'b0, 10'h3FE, 11'd4);
        chk("wr_busy", 32'(busy), 1);
        send(32'hA0);
        start = 1'b1;
        mode = 1'b1;
        base_addr = 10'h055;
        length = 11'd1;
        send(32'hA1);
        start = 1'b0;
        send(32'hA2);
        send(32'hA3);
        chk("wr_done_lat", 32'(done), 1);
        chk("wr_s_ready_off", 32'(bus.s_ready), 0);
        step();
        chk("wr_idle", 32'(busy), 0);
        chk("wr_done_pulse", 32'(done), 0);
        chk("wr_q_empty", 32'(wq.size()), 0);
        // read the same region back at full rate
        for (int i = 0; i < 4; i++) rq.push_back(32'hA0 + i);
        bus.m_ready = 1'b1;
        p0 = pop_cyc.size();
        launch(1'b1, 10'h3FE, 11'd4);
        wait_done(1'b0, at);
        chk("rd_count", 32'(pop_cyc.size() - p0), 4);
        if (pop_cyc.size() - p0 == 4) begin
            chk("rd_back2back", 32'(pop_cyc[p0+3] - pop_cyc[p0]), 3);
            chk("rd_done_lat", 32'(at - pop_cyc[p0+3]), 1);
        end
        step();
        // eight words at 0x100, then read them back under alternating backpressure
        for (int i = 0; i < 8; i++) wq.push_back('{AW'(10'h100 + i), 32'hB0 + i});
        launch(1'b0, 10'h100, 11'd8);
        for (int i = 0; i < 8; i++) send(32'hB0 + i);
        chk("wr8_done", 32'(done), 1);
        step();
        for (int i = 0; i < 8; i++) rq.push_back(32'hB0 + i);
        bus.m_ready = 1'b0;
        p0 = pop_cyc.size();
        launch(1'b1, 10'h100, 11'd8);
        wait_done(1'b1, at);
        bus.m_ready = 1'b1;
        chk("rd8_count", 32'(pop_cyc.size() - p0), 8);
        chk("rd8_q_empty", 32'(rq.size()), 0);
        step();
        // zero-length transfer touches nothing and pulses done once
        d0 = done_cnt;
        e0 = en_cnt;
        launch(1'b1, 10'h020, 11'd0);
        chk("len0_done", 32'(done), 1);
        repeat (4) step();
        chk("len0_pulses", 32'(done_cnt - d0), 1);
        chk("len0_no_en", 32'(en_cnt - e0), 0);
        // reset after three words of an eight-word read
        for (int i = 0; i < 8; i++) rq.push_back(32'hB0 + i);
        p0 = pop_cyc.size();
        launch(1'b1, 10'h100, 11'd8);
        n = 0;
        while (pop_cyc.size() - p0 < 3 && n < 50) begin
            step();
            n++;
        end
        chk("rst_mid_reached", 32'(pop_cyc.size() - p0), 3);
        bus.m_ready = 1'b0;
        rst = 1'b1;
        d0 = done_cnt;
        step();
        chk("rst_mid_m_valid", 32'(bus.m_valid), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_done", 32'(done), 0);
        rq.delete();
        step();
        rst = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) step();
        chk("rst_mid_no_done", 32'(done_cnt - d0), 0);
        chk("rst_mid_popped", 32'(pop_cyc.size() - p0), 3);
        // clean read after the abort
        rq.push_back(32'hB0);
        rq.push_back(32'hB1);
        p0 = pop_cyc.size();
        launch(1'b1, 10'h100, 11'd2);
        wait_done(1'b0, at);
        chk("post_rst_count", 32'(pop_cyc.size() - p0), 2);
        step();
`ifdef LDM_DMA_STRIDE_EN
        wq.push_back('{10'h000, 32'hC0});
        wq.push_back('{10'h004, 32'hC1});
        wq.push_back('{10'h008, 32'hC2});
        cfg_stride = 10'd4;
        launch(1'b0, 10'h000, 11'd3);
        cfg_stride = 10'd1;
        send(32'hC0);
        send(32'hC1);
        send(32'hC2);
        chk("stride_done", 32'(done), 1);
        step();
`endif
        chk("final_wq_empty", 32'(wq.size()), 0);
        chk("final_rq_empty", 32'(rq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
